// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among functional-unit result
// requests, driving a registered CDB broadcast plus conflict and utilisation status.
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        req_i,
  input  logic [NUM_FU*TAG_W-1:0]  tag_i,
  input  logic [NUM_FU*DATA_W-1:0] data_i,
  output logic                     cdb_valid_o,
  output logic [TAG_W-1:0]         cdb_tag_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output logic [NUM_FU-1:0]        grant_o,
  output logic                     conflict_o,
  output logic [CNT_W-1:0]         busy_cnt_o
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic                r_valid;
  logic [TAG_W-1:0]    r_tag;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_FU-1:0]   r_grant;
  logic                r_conflict;
  logic [CNT_W-1:0]    r_busy_cnt;
  logic [PTR_W-1:0]    r_ptr;

  logic [NUM_FU-1:0]   w_mask;
  logic [NUM_FU-1:0]   w_elig;
  logic [2*NUM_FU-1:0] w_shift;
  logic [PTR_W-1:0]    w_off;
  logic                w_found;
  logic                w_seen;
  logic                w_multi;
  logic [PTR_W:0]      w_sum;
  logic [PTR_W:0]      w_inc;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W-1:0]    w_nxt_ptr;
  logic [NUM_FU-1:0]   w_gnt;
  logic [TAG_W-1:0]    w_tag;
  logic [DATA_W-1:0]   w_data;

  assign w_mask = r_valid ? r_grant : '0;
  assign w_elig = req_i & ~w_mask;

  // Rotate the eligible vector so the pointer lands on bit 0; the first set
  // bit is then the offset of the winner from the pointer.
  always_comb begin
    w_shift = {w_elig, w_elig} >> r_ptr;
    w_found = 1'b0;
    w_off   = '0;
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (!w_found && w_shift[i]) begin
        w_found = 1'b1;
        w_off   = PTR_W'(i);
      end
      if (w_elig[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (PTR_W+1)'(NUM_FU)) w_win = PTR_W'(w_sum - (PTR_W+1)'(NUM_FU));
    else                             w_win = w_sum[PTR_W-1:0];
    w_inc = {1'b0, w_win} + (PTR_W+1)'(1);
    if (w_inc >= (PTR_W+1)'(NUM_FU)) w_nxt_ptr = '0;
    else                             w_nxt_ptr = w_inc[PTR_W-1:0];
  end

  always_comb begin
    w_gnt  = '0;
    w_tag  = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_gnt[i] = 1'b1;
        w_tag    = tag_i[i*TAG_W +: TAG_W];
        w_data   = data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Flush wins over any request; clearing valid also clears next cycle's mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_data     <= '0;
      r_grant    <= '0;
      r_conflict <= 1'b0;
      r_busy_cnt <= '0;
      r_ptr      <= '0;
    end else if (flush || !w_found) begin
      r_valid    <= 1'b0;
      r_grant    <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_valid    <= 1'b1;
      r_tag      <= w_tag;
      r_data     <= w_data;
      r_grant    <= w_gnt;
      r_conflict <= w_multi;
      r_ptr      <= w_nxt_ptr;
      if (r_busy_cnt != '1) r_busy_cnt <= r_busy_cnt + 1'b1;
    end
  end

  assign cdb_valid_o = r_valid;
  assign cdb_tag_o   = r_tag;
  assign cdb_data_o  = r_data;
  assign grant_o     = r_grant;
  assign conflict_o  = r_conflict;
  assign busy_cnt_o  = r_busy_cnt;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of every functional-unit wrapper (add/sub, mul, div, load). It collects their `cdb_request` and tagged results and grants one unit per cycle using round-robin.
- It drives the registered Common Data Bus broadcast (valid, tag, data). Reservation stations, the register-status table and the requesting FUs all snoop this broadcast; an FU's own tag on the bus is its "result taken" acknowledgement.

Parameters:
- NUM_FU, 4, number of requesting functional units; index 0..NUM_FU-1.
- TAG_W, 8, tag width; tag[7:3] = FU tag, tag[2:0] = one-hot RS index.
- DATA_W, 32, result data width.
- CNT_W, 16, width of the bus-utilisation counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; cancels the next broadcast.
- req_i  in  NUM_FU  per-FU cdb_request.
- tag_i  in  NUM_FU*TAG_W  packed per-FU result tag; FU k occupies slice [k*TAG_W +: TAG_W].
- data_i  in  NUM_FU*DATA_W  packed per-FU result value; FU k occupies slice [k*DATA_W +: DATA_W].
- cdb_valid_o  out  1  broadcast valid.
- cdb_tag_o  out  TAG_W  broadcast tag.
- cdb_data_o  out  DATA_W  broadcast value.
- grant_o  out  NUM_FU  one-hot index of the FU currently on the bus; all zero when idle.
- conflict_o  out  1  registered; 1 when more than one eligible requester competed for the current broadcast.
- busy_cnt_o  out  CNT_W  count of cycles carrying a valid broadcast; saturating.

Behaviour:
- Reset (rst_n=0, takes effect immediately, asynchronous):
  - cdb_valid_o=0, cdb_tag_o=0, cdb_data_o=0, grant_o=0, conflict_o=0, busy_cnt_o=0.
  - Round-robin pointer ptr=0; last-winner mask=0.
  - Reset mid-broadcast drops cdb_valid_o immediately.
- Eligibility:
  - eligible = req_i & ~mask.
  - mask = grant_o when cdb_valid_o=1, otherwise 0.
  - Effect: the FU currently on the bus cannot win the next slot. This gives it one cycle to observe its tag and drop its request.
- Winner: first eligible index scanning ptr, ptr+1, ..., wrapping modulo NUM_FU.
- Posedge with flush=0 and an eligible requester:
  - cdb_valid_o<=1.
  - cdb_tag_o<=tag slice of the winner; cdb_data_o<=data slice of the winner.
  - grant_o<=onehot(winner).
  - ptr<=(winner+1) mod NUM_FU.
  - conflict_o<=(popcount(eligible)>1).
  - busy_cnt_o<=busy_cnt_o+1, saturating at all-ones.
- Posedge with flush=0 and no eligible requester:
  - cdb_valid_o<=0, grant_o<=0, conflict_o<=0.
  - cdb_tag_o and cdb_data_o hold their previous values; ptr unchanged.
- Posedge with flush=1: takes priority over any request.
  - cdb_valid_o<=0, grant_o<=0, conflict_o<=0; the mask effectively clears.
  - ptr unchanged; no grant; counter unchanged.
  - Requests still asserted are re-arbitrated from the next cycle.
- Latency: a request sampled at posedge T is broadcast during cycle T..T+1. The output is registered with no combinational path from req_i, tag_i or data_i to any output.
- Handshake:
  - An FU holds req_i, tag_i and data_i stable until it sees cdb_valid_o with its own FU tag.
  - Data is sampled only at the grant edge; later changes to data_i do not affect the bus.
- Boundary conditions:
  - A lone, continuously requesting FU is granted every other cycle.
  - With all NUM_FU requesting continuously, every FU is granted within NUM_FU cycles; no starvation.
  - If req_i carries a tag whose RS field is 000, it is still arbitrated; no tag checking is done in this block.

Test Plan:
- Async reset asserted between edges while cdb_valid_o=1 -> all outputs go to 0 immediately, without waiting for clk; the first grant after release goes to the lowest requesting index.
- req_i=0001 held, tag_i[0]=8'h2C, data_i[0]=32'h0000_0007 -> cdb_valid_o pattern 1,0,1,0; grant_o=0001 on valid cycles; cdb_tag_o=8'h2C, cdb_data_o=7.
- From reset, req_i=0111 held -> grant_o sequence 0001, 0010, 0100, 0001; conflict_o=1 on each of these cycles; busy_cnt_o=4 after 4 cycles.
- ptr=3, req_i=1001 -> FU3 granted first, then FU0; conflict_o=1 then 0.
- req_i=0110 with flush=1 on the grant edge -> cdb_valid_o=0, busy_cnt_o unchanged; next edge grants FU1 (ptr not advanced).
- CNT_W=4, continuous grants for 20 cycles -> busy_cnt_o saturates at 4'hF.
